// File: rtl/ibex_pkg.sv
// Shared types for the writeback arbiter: load-queue entry metadata, write-port source select
// and register-address compare helpers that honour the RV32E 16-register file.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EX,
    WB_SRC_LSU
  } wb_src_e;

  // Load data is held in a separate DataWidth-wide array beside this metadata.
  typedef struct packed {
    logic [4:0] waddr;
    logic       done;
    logic       err;
  } wb_lq_entry_t;

  function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b, input bit rv32e);
    return rv32e ? (a[3:0] == b[3:0]) : (a == b);
  endfunction

  function automatic logic regIsZero(input logic [4:0] a, input bit rv32e);
    return rv32e ? (a[3:0] == 4'd0) : (a == 5'd0);
  endfunction

endpackage

// File: rtl/ibex_wb_load_queue.sv
// Circular in-order queue of outstanding loads: allocation, response fill, head pop,
// and destination compares against the EX write address and both ID read addresses.
module ibex_wb_load_queue
  import ibex_pkg::*;
#(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  logic [4:0]           alloc_waddr_i,
  input  logic                 fill_i,
  input  logic [DataWidth-1:0] fill_data_i,
  input  logic                 fill_err_i,
  input  logic                 pop_i,
  input  logic [4:0]           cmp_ex_i,
  input  logic [4:0]           cmp_a_i,
  input  logic [4:0]           cmp_b_i,
  output logic [CntW-1:0]      count_o,
  output logic                 head_done_o,
  output logic                 head_err_o,
  output logic [4:0]           head_waddr_o,
  output logic [DataWidth-1:0] head_data_o,
  output logic                 hit_ex_o,
  output logic                 hit_a_o,
  output logic                 hit_b_o
);

  wb_lq_entry_t         entry_q [MaxOutstanding];
  logic [DataWidth-1:0] data_q  [MaxOutstanding];
  logic [MaxOutstanding-1:0] valid_q;
  logic [PtrW-1:0] allocPtr_q, allocPtr_d;
  logic [PtrW-1:0] fillPtr_q, fillPtr_d;
  logic [PtrW-1:0] headPtr_q, headPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fillEn;
  logic            anyEx, anyA, anyB;

  function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // A response only lands on an allocated entry still waiting for data; anything else is dropped.
  assign fillEn = fill_i & valid_q[fillPtr_q] & ~entry_q[fillPtr_q].done;

  always_comb begin
    allocPtr_d = alloc_i ? ptrInc(allocPtr_q) : allocPtr_q;
    fillPtr_d  = fillEn  ? ptrInc(fillPtr_q)  : fillPtr_q;
    headPtr_d  = pop_i   ? ptrInc(headPtr_q)  : headPtr_q;
    count_d    = count_q + CntW'(alloc_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      allocPtr_q <= '0;
      fillPtr_q  <= '0;
      headPtr_q  <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        entry_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      allocPtr_q <= allocPtr_d;
      fillPtr_q  <= fillPtr_d;
      headPtr_q  <= headPtr_d;
      count_q    <= count_d;
      if (pop_i) valid_q[headPtr_q] <= 1'b0;
      if (fillEn) begin
        entry_q[fillPtr_q].done <= 1'b1;
        entry_q[fillPtr_q].err  <= fill_err_i;
        data_q[fillPtr_q]       <= fill_data_i;
      end
      if (alloc_i) begin
        valid_q[allocPtr_q] <= 1'b1;
        entry_q[allocPtr_q] <= '{waddr: alloc_waddr_i, done: 1'b0, err: 1'b0};
      end
    end
  end

  always_comb begin
    anyEx = 1'b0;
    anyA  = 1'b0;
    anyB  = 1'b0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (valid_q[i]) begin
        if (regMatch(entry_q[i].waddr, cmp_ex_i, RV32E)) anyEx = 1'b1;
        if (regMatch(entry_q[i].waddr, cmp_a_i, RV32E))  anyA  = 1'b1;
        if (regMatch(entry_q[i].waddr, cmp_b_i, RV32E))  anyB  = 1'b1;
      end
    end
  end

  // x0 is never a real dependency, so it never reports a hit.
  assign hit_ex_o = anyEx & ~regIsZero(cmp_ex_i, RV32E);
  assign hit_a_o  = anyA  & ~regIsZero(cmp_a_i, RV32E);
  assign hit_b_o  = anyB  & ~regIsZero(cmp_b_i, RV32E);

  assign count_o      = count_q;
  assign head_done_o  = valid_q[headPtr_q] & entry_q[headPtr_q].done;
  assign head_err_o   = entry_q[headPtr_q].err;
  assign head_waddr_o = entry_q[headPtr_q].waddr;
  assign head_data_o  = data_q[headPtr_q];

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Writeback arbiter in front of the register file: merges EX results and in-order load
// responses onto one write port, raises RAW stalls and holds EX writes that would reorder WAW.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_req_waddr_i,
  output logic                 lsu_req_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 stall_a_o,
  output logic                 stall_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0]      count;
  logic                 headDone, headErr, headZero;
  logic [4:0]           headWaddr;
  logic [DataWidth-1:0] headData;
  logic                 exWaw, full, alloc, pop;
  wb_src_e              wbSrc;
  logic [4:0]           waddrSel;

  ibex_wb_load_queue #(
    .RV32E          (RV32E),
    .DataWidth      (DataWidth),
    .MaxOutstanding (MaxOutstanding)
  ) uLoadQueue (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (alloc),
    .alloc_waddr_i (lsu_req_waddr_i),
    .fill_i        (lsu_rvalid_i),
    .fill_data_i   (lsu_rdata_i),
    .fill_err_i    (lsu_err_i),
    .pop_i         (pop),
    .cmp_ex_i      (ex_waddr_i),
    .cmp_a_i       (raddr_a_i),
    .cmp_b_i       (raddr_b_i),
    .count_o       (count),
    .head_done_o   (headDone),
    .head_err_o    (headErr),
    .head_waddr_o  (headWaddr),
    .head_data_o   (headData),
    .hit_ex_o      (exWaw),
    .hit_a_o       (stall_a_o),
    .hit_b_o       (stall_b_o)
  );

  assign full            = (count == CntW'(MaxOutstanding));
  assign lsu_req_ready_o = ~full;
  assign alloc           = lsu_req_i & ~full;
  assign busy_o          = (count != '0);
  assign headZero        = regIsZero(headWaddr, RV32E);

  // The load head also takes the port while EX is blocked on WAW, otherwise an EX write
  // to a pending load's destination would wait on a head that waits on EX.
  always_comb begin
    wbSrc      = WB_SRC_NONE;
    ex_ready_o = 1'b0;
    pop        = 1'b0;
    rf_we_o    = 1'b0;
    waddrSel   = '0;
    rf_wdata_o = '0;
    if (headDone & ~headErr & ~headZero & (full | ~ex_valid_i | exWaw)) begin
      wbSrc = WB_SRC_LSU;
      pop   = 1'b1;
    end else if (ex_valid_i & ~exWaw) begin
      wbSrc      = WB_SRC_EX;
      ex_ready_o = 1'b1;
    end
    if (headDone & (headErr | headZero)) pop = 1'b1;
    case (wbSrc)
      WB_SRC_LSU: begin
        rf_we_o    = 1'b1;
        waddrSel   = headWaddr;
        rf_wdata_o = headData;
      end
      WB_SRC_EX: begin
        if (!regIsZero(ex_waddr_i, RV32E)) begin
          rf_we_o    = 1'b1;
          waddrSel   = ex_waddr_i;
          rf_wdata_o = ex_wdata_i;
        end
      end
      default: ;
    endcase
  end

  assign rf_waddr_o = RV32E ? {1'b0, waddrSel[3:0]} : waddrSel;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: directed per-cycle vector table, a mid-operation
// reset sequence, then randomized traffic against a queue-based reference model.
module tb_ibex_rf_wb_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid_i;
  logic [4:0]    ex_waddr_i;
  logic [DW-1:0] ex_wdata_i;
  logic          ex_ready_o;
  logic          lsu_req_i;
  logic [4:0]    lsu_req_waddr_i;
  logic          lsu_req_ready_o;
  logic          lsu_rvalid_i;
  logic [DW-1:0] lsu_rdata_i;
  logic          lsu_err_i;
  logic [4:0]    raddr_a_i, raddr_b_i;
  logic          stall_a_o, stall_b_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          busy_o;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] dutRf [32];

  typedef struct {
    logic exV; logic [4:0] exA; logic [31:0] exD;
    logic req; logic [4:0] reqA;
    logic rv; logic [31:0] rd; logic err;
    logic [4:0] ra; logic [4:0] rb;
    logic eExReady; logic eReqReady; logic eStallA; logic eStallB;
    logic eWe; logic [4:0] eWaddr; logic [31:0] eWdata; logic eBusy;
  } vec_t;

  typedef struct {
    logic [4:0] a; logic done; logic err; logic [31:0] d;
  } mEntry_t;

  vec_t    vecs[$];
  mEntry_t lq[$];

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(DW), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .lsu_req_i(lsu_req_i), .lsu_req_waddr_i(lsu_req_waddr_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .stall_a_o(stall_a_o), .stall_b_o(stall_b_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  // Mirror of what the register file captures, used for end-value checks.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) dutRf[i] <= '0;
    end else if (rf_we_o) begin
      dutRf[rf_waddr_o] <= rf_wdata_o;
    end
  end

  task automatic addVec(input int exV, input int exA, input logic [31:0] exD,
                        input int req, input int reqA,
                        input int rv, input logic [31:0] rd, input int err,
                        input int ra, input int rb,
                        input int eExReady, input int eReqReady, input int eStallA, input int eStallB,
                        input int eWe, input int eWaddr, input logic [31:0] eWdata, input int eBusy);
    vec_t v;
    v.exV = exV[0]; v.exA = exA[4:0]; v.exD = exD;
    v.req = req[0]; v.reqA = reqA[4:0];
    v.rv = rv[0]; v.rd = rd; v.err = err[0];
    v.ra = ra[4:0]; v.rb = rb[4:0];
    v.eExReady = eExReady[0]; v.eReqReady = eReqReady[0];
    v.eStallA = eStallA[0]; v.eStallB = eStallB[0];
    v.eWe = eWe[0]; v.eWaddr = eWaddr[4:0]; v.eWdata = eWdata; v.eBusy = eBusy[0];
    vecs.push_back(v);
  endtask

  task automatic clearInputs();
    ex_valid_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    lsu_req_i = 1'b0; lsu_req_waddr_i = '0;
    lsu_rvalid_i = 1'b0; lsu_rdata_i = '0; lsu_err_i = 1'b0;
    raddr_a_i = '0; raddr_b_i = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    ex_valid_i = v.exV; ex_waddr_i = v.exA; ex_wdata_i = v.exD;
    lsu_req_i = v.req; lsu_req_waddr_i = v.reqA;
    lsu_rvalid_i = v.rv; lsu_rdata_i = v.rd; lsu_err_i = v.err;
    raddr_a_i = v.ra; raddr_b_i = v.rb;
  endtask

  task automatic checkOutput(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, got, exp);
    end
  endtask

  task automatic checkAll(input int id, input logic eExReady, input logic eReqReady,
                          input logic eStallA, input logic eStallB, input logic eWe,
                          input logic [4:0] eWaddr, input logic [31:0] eWdata, input logic eBusy);
    checkOutput("ex_ready", id, 32'(ex_ready_o), 32'(eExReady));
    checkOutput("lsu_req_ready", id, 32'(lsu_req_ready_o), 32'(eReqReady));
    checkOutput("stall_a", id, 32'(stall_a_o), 32'(eStallA));
    checkOutput("stall_b", id, 32'(stall_b_o), 32'(eStallB));
    checkOutput("rf_we", id, 32'(rf_we_o), 32'(eWe));
    checkOutput("rf_waddr", id, 32'(rf_waddr_o), 32'(eWaddr));
    checkOutput("rf_wdata", id, rf_wdata_o, eWdata);
    checkOutput("busy", id, 32'(busy_o), 32'(eBusy));
  endtask

  function automatic bit pendingHas(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (lq[i]) if (lq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic runRandom(input int cycles);
    bit exTaken, full, exWaw, headDone, headDrop, lsuWr, exAcc, we, undone;
    logic [4:0]  wa;
    logic [31:0] wd;
    int n;
    exTaken = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge clk);
      #1;
      if (exTaken) begin
        ex_valid_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
      end
      if (!ex_valid_i && $urandom_range(0, 2) == 0) begin
        ex_valid_i = 1'b1;
        ex_waddr_i = 5'($urandom_range(0, 7));
        ex_wdata_i = $urandom;
      end
      lsu_req_i = ($urandom_range(0, 2) == 0);
      lsu_req_waddr_i = 5'($urandom_range(0, 7));
      undone = 1'b0;
      foreach (lq[i]) if (!lq[i].done) undone = 1'b1;
      lsu_rvalid_i = undone ? ($urandom_range(0, 1) == 1) : (!lsu_req_i && $urandom_range(0, 7) == 0);
      lsu_rdata_i = $urandom;
      lsu_err_i = ($urandom_range(0, 7) == 0);
      raddr_a_i = 5'($urandom_range(0, 7));
      raddr_b_i = 5'($urandom_range(0, 7));
      @(negedge clk);

      n = lq.size();
      full = (n == 2);
      exWaw = ex_valid_i && pendingHas(ex_waddr_i);
      headDone = 1'b0; headDrop = 1'b0; lsuWr = 1'b0;
      if (n > 0 && lq[0].done) begin
        headDone = 1'b1;
        headDrop = lq[0].err || lq[0].a == 5'd0;
        lsuWr = !headDrop && (full || !ex_valid_i || exWaw);
      end
      exAcc = ex_valid_i && !lsuWr && !exWaw;
      we = lsuWr || (exAcc && ex_waddr_i != 5'd0);
      wa = lsuWr ? lq[0].a : (we ? ex_waddr_i : 5'd0);
      wd = lsuWr ? lq[0].d : (we ? ex_wdata_i : 32'd0);
      checkAll(1000 + cyc, exAcc, !full, pendingHas(raddr_a_i), pendingHas(raddr_b_i),
               we, wa, wd, n != 0);

      exTaken = exAcc;
      if (headDone && (lsuWr || headDrop)) void'(lq.pop_front());
      if (lsu_rvalid_i) begin
        for (int i = 0; i < lq.size(); i++) begin
          if (!lq[i].done) begin
            lq[i].done = 1'b1; lq[i].err = lsu_err_i; lq[i].d = lsu_rdata_i;
            break;
          end
        end
      end
      if (lsu_req_i && !full) lq.push_back('{a: lsu_req_waddr_i, done: 1'b0, err: 1'b0, d: 32'd0});
    end
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load x5, response two cycles later, write one cycle after, stall drops after the write.
    addVec(0,0,0, 1,5, 0,0,0, 5,0, 0,1,0,0, 0,0,0, 0);
    addVec(0,0,0, 0,0, 0,0,0, 5,0, 0,1,1,0, 0,0,0, 1);
    addVec(0,0,0, 0,0, 1,'h1234,0, 5,0, 0,1,1,0, 0,0,0, 1);
    addVec(0,0,0, 0,0, 0,0,0, 5,0, 0,1,1,0, 1,5,'h1234, 1);
    addVec(0,0,0, 0,0, 0,0,0, 5,0, 0,1,0,0, 0,0,0, 0);
    // Two loads fill the queue; a third is held off until the first commits.
    addVec(0,0,0, 1,3, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);
    addVec(0,0,0, 1,4, 0,0,0, 3,0, 0,1,1,0, 0,0,0, 1);
    addVec(0,0,0, 1,8, 0,0,0, 4,0, 0,0,1,0, 0,0,0, 1);
    addVec(0,0,0, 1,8, 1,'h33,0, 0,0, 0,0,0,0, 0,0,0, 1);
    addVec(0,0,0, 1,8, 1,'h44,0, 0,0, 0,0,0,0, 1,3,'h33, 1);
    addVec(0,0,0, 1,8, 0,0,0, 0,0, 0,1,0,0, 1,4,'h44, 1);
    addVec(0,0,0, 0,0, 0,0,0, 0,8, 0,1,0,1, 0,0,0, 1);
    addVec(0,0,0, 0,0, 1,'h88,0, 0,8, 0,1,0,1, 0,0,0, 1);
    addVec(0,0,0, 0,0, 0,0,0, 0,8, 0,1,0,1, 1,8,'h88, 1);
    addVec(0,0,0, 0,0, 0,0,0, 0,8, 0,1,0,0, 0,0,0, 0);
    // Full queue with done head wins over EX x7; EX writes the next cycle.
    addVec(0,0,0, 1,10, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);
    addVec(0,0,0, 1,11, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 1);
    addVec(0,0,0, 0,0, 1,'hA0,0, 0,0, 0,0,0,0, 0,0,0, 1);
    addVec(1,7,'h77, 0,0, 0,0,0, 0,0, 0,0,0,0, 1,10,'hA0, 1);
    addVec(1,7,'h77, 0,0, 0,0,0, 0,0, 1,1,0,0, 1,7,'h77, 1);
    addVec(0,0,0, 0,0, 1,'hB0,0, 0,0, 0,1,0,0, 0,0,0, 1);
    addVec(0,0,0, 0,0, 0,0,0, 0,0, 0,1,0,0, 1,11,'hB0, 1);
    addVec(0,0,0, 0,0, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);
    // WAW: EX x6 held while load x6 is pending; EX data must land last.
    addVec(0,0,0, 1,6, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);
    addVec(1,6,'h66, 0,0, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 1);
    addVec(1,6,'h66, 0,0, 1,'h60,0, 0,0, 0,1,0,0, 0,0,0, 1);
    addVec(1,6,'h66, 0,0, 0,0,0, 0,0, 0,1,0,0, 1,6,'h60, 1);
    addVec(1,6,'h66, 0,0, 0,0,0, 0,0, 1,1,0,0, 1,6,'h66, 0);
    addVec(0,0,0, 0,0, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);
    // Faulted load to x9 retires silently while an EX write goes through.
    addVec(0,0,0, 1,9, 0,0,0, 9,0, 0,1,0,0, 0,0,0, 0);
    addVec(0,0,0, 0,0, 1,'hDEAD,1, 9,0, 0,1,1,0, 0,0,0, 1);
    addVec(1,12,'hC0, 0,0, 0,0,0, 9,0, 1,1,1,0, 1,12,'hC0, 1);
    addVec(0,0,0, 0,0, 0,0,0, 9,0, 0,1,0,0, 0,0,0, 0);
    // EX write to x0 is accepted without using the port.
    addVec(1,0,'h55, 0,0, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 0);
    addVec(0,0,0, 0,0, 0,0,0, 0,0, 0,1,0,0, 0,0,0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkAll(i + 1, vecs[i].eExReady, vecs[i].eReqReady, vecs[i].eStallA, vecs[i].eStallB,
               vecs[i].eWe, vecs[i].eWaddr, vecs[i].eWdata, vecs[i].eBusy);
    end
    checkOutput("rf_x6_final", 90, dutRf[6], 32'h66);
    checkOutput("rf_x12_final", 91, dutRf[12], 32'hC0);
    checkOutput("rf_x9_unwritten", 92, dutRf[9], 32'h0);

    // Reset with two loads pending, then a late response that must be ignored.
    @(posedge clk); #1;
    clearInputs();
    lsu_req_i = 1'b1; lsu_req_waddr_i = 5'd13;
    @(posedge clk); #1;
    lsu_req_waddr_i = 5'd14;
    @(posedge clk); #1;
    lsu_req_i = 1'b0; raddr_a_i = 5'd13; raddr_b_i = 5'd14;
    @(negedge clk);
    checkAll(100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkAll(101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hBAD;
    @(negedge clk);
    checkAll(102, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    lsu_rvalid_i = 1'b0;
    @(negedge clk);
    checkAll(103, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rf_x13_after_reset", 104, dutRf[13], 32'h0);
    clearInputs();

    runRandom(1500);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
